// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage for the single-cycle RISC-V core. Owns the program
// counter, fetches one 32-bit word at a time from instruction memory over a
// req/ack handshake, and holds the fetched instruction for decode until the
// core retires it. The next PC is then either sequential (+4) or the branch
// target sampled with retire.
//
// Parameters
//   RESET_PC   PC loaded on reset.
//   NOP_INSTR  instruction register value after reset (addi x0,x0,0).
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   stall          in   holds off starting a new fetch
//   imem_req       out  registered fetch request
//   imem_addr      out  fetch address (always equals pc)
//   imem_ack       in   imem_rdata valid this cycle
//   imem_rdata     in   fetched instruction word
//   instr          out  registered instruction to decode
//   pc             out  address of instr / current fetch
//   instr_valid    out  instr valid and awaiting retirement
//   retire         in   core finished executing instr
//   branch_taken   in   with retire: next PC is branch_target
//   branch_target  in   with retire: branch destination
//   fetch_err      out  sticky misaligned-target error
//
// Build option
//   FETCH_MISALIGN_TRAP_EN  when defined, a taken branch to a target with
//                           non-zero low bits sets fetch_err and parks the
//                           block in HALT until reset. When undefined, the
//                           low two target bits are cleared on load and
//                           fetch_err is constant 0.
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        instr_valid,
  input  logic        retire,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] next_pc;

  assign imem_addr = pc;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;
  logic err_q;

  assign misaligned = branch_taken && (branch_target[1:0] != 2'b00);
  assign next_pc    = branch_taken ? branch_target : pc + 32'd4;
  assign fetch_err  = err_q;
`else
  // Low target bits are dropped so the PC stays word aligned.
  logic unused_target_bits;

  assign unused_target_bits = ^branch_target[1:0];
  assign next_pc   = branch_taken ? {branch_target[31:2], 2'b00} : pc + 32'd4;
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!stall) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end

        // stall is deliberately not consulted: a request in flight completes.
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= EXEC;
          end
        end

        EXEC: begin
          if (retire) begin
            instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misaligned) begin
              // PC keeps the faulting instruction's address for debug.
              err_q <= 1'b1;
              state <= HALT;
            end else
`endif
            begin
              pc <= next_pc;
              if (stall) begin
                state <= IDLE;
              end else begin
                state    <= FETCH;
                imem_req <= 1'b1;
              end
            end
          end
        end

        HALT: begin
`ifdef FETCH_MISALIGN_TRAP_EN
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
`else
          state <= IDLE;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the single-cycle RISC-V core. It owns the program counter, fetches one 32-bit instruction at a time from instruction memory over a req/ack handshake, and presents it to decode, which slices `opcode` into the control decoder. It holds the instruction stable until the core retires it, then selects the next PC as sequential (+4) or the taken-branch target.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013: instruction register value after reset (addi x0,x0,0).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  holds off starting a new fetch.
- `imem_req`  out  1  fetch request, registered.
- `imem_addr`  out  32  fetch address; always equals `pc`.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  instruction to decode, registered.
- `pc`  out  32  address of `instr` / current fetch.
- `instr_valid`  out  1  `instr` is valid and awaiting retirement.
- `retire`  in  1  core finished executing `instr`.
- `branch_taken`  in  1  sampled with `retire`: the next PC is the branch target.
- `branch_target`  in  32  sampled with `retire`.
- `fetch_err`  out  1  sticky misaligned-target error; tied 0 when the feature is compiled out.

## Operation
- Clocking: one clock `clk`. Reset is synchronous and active-high on `reset`.
- States: IDLE, FETCH, EXEC, and HALT (HALT exists only with the macro).
- Reset values:
  - state=IDLE, `pc`=RESET_PC, `instr`=NOP_INSTR.
  - `imem_req`=0, `instr_valid`=0, `fetch_err`=0.
- IDLE:
  - `stall`=0: go to FETCH and set `imem_req`=1 at the same edge.
  - `stall`=1: remain in IDLE.
- FETCH:
  - `imem_req` stays 1 and `imem_addr` stays stable until `imem_ack` is sampled high.
  - On ack: `instr`<=`imem_rdata`, `imem_req`<=0, `instr_valid`<=1, go to EXEC.
  - `stall` is ignored here. An in-flight request is never abandoned except by reset.
- EXEC:
  - `instr`, `pc` and `instr_valid`=1 are held until `retire` is sampled high.
  - On retire: `pc`<=`branch_taken` ? `branch_target` : `pc`+4, and `instr_valid`<=0.
  - Then, if `stall`=0: go to FETCH and set `imem_req`<=1 at the same edge. If `stall`=1: go to IDLE.
- `pc`+4 is a 32-bit add and wraps: 32'hFFFF_FFFC goes to 32'h0000_0000.
- `imem_ack` outside FETCH is ignored.
- `retire` outside EXEC is ignored. `branch_taken` and `branch_target` are don't-care without `retire`.

## Timing
- `imem_ack` may arrive in the first cycle `imem_req` is high (zero-wait memory) or any later cycle.
- Latency from ack-sampling edge to `instr_valid`=1 is the same edge (registered output visible next cycle).
- Zero-wait memory, no stall, `retire` in the first EXEC cycle gives a steady 2 cycles per instruction: FETCH, EXEC.
- `pc` changes only on the retire edge or on reset.
- Reset mid-FETCH: `imem_req` drops at the reset edge. A late ack afterwards is ignored because state is IDLE.
- Reset mid-EXEC: `instr` returns to NOP_INSTR and `instr_valid`=0.
- Reset has priority over every simultaneous event.
- `stall` and `retire` high together in EXEC: the PC updates and the block enters IDLE.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - Trigger: a retire with `branch_taken`=1 and `branch_target[1:0]`≠0.
  - `pc` is not updated and `fetch_err`<=1.
  - The block enters HALT: no further requests, `instr_valid`=0.
  - It stays in HALT until reset.
- Not defined:
  - `branch_target[1:0]` is forced to 2'b00 on load.
  - HALT does not exist.
  - `fetch_err` is constant 0.

## Test plan
- Reset, then release with `stall`=0 and zero-wait memory returning 32'h0050_0093 → `imem_addr`=0, `instr`=32'h0050_0093 and `instr_valid`=1 two cycles after reset release. Then `retire` with no branch → next `imem_addr`=32'h4.
- Ack delayed by 3 cycles → `imem_req` and `imem_addr` are held stable for 4 cycles, and `instr_valid` rises only after the ack edge.
- Retire with `branch_taken`=1 and `branch_target`=32'h0000_0100 → next fetch address is 32'h100. With `branch_taken`=0 at `pc`=32'hFFFF_FFFC → next fetch address is 0.
- `stall`=1 held through retire for 5 cycles → stays in IDLE with `imem_req`=0 and `pc` already updated. Stall release → FETCH on the next edge.
- Reset asserted while `imem_req`=1, with ack one cycle later → `instr`=32'h0000_0013, `instr_valid`=0, and `pc`=RESET_PC.
- Taken branch to 32'h0000_0102:
  - With the macro → `fetch_err`=1, `pc` unchanged, no `imem_req` until reset.
  - Without the macro → fetch from 32'h100 and `fetch_err`=0.
